// File: rtl/alu_trainer_pkg.sv
// Shared definitions for the 2-bit ALU trainer: op encodings, sweep FSM states
// and the reference ALU behaviour.
package alu_trainer_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Results wrap modulo 4, so ADD/SUB simply keep the low two bits.
    function automatic logic [1:0] alu_golden(input logic [1:0] a,
                                              input logic [1:0] b,
                                              input logic [1:0] op);
        logic [1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            default: r = a - b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_tick_gen.sv
// Prescaler: while enabled, emits a one-cycle tick every TICK_DIV cycles.
// Holding enable low freezes the count so it resumes where it left off.
module alu_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Walks all 64 {op, a, b} vectors through an external 2-bit ALU, checks each
// result against the reference model and reports error count, last failure and pass.
module alu_sweep_driver
    import alu_trainer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       step,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [1:0] alu_result,
    output logic       busy,
    output logic       done,
    output logic [6:0] err_count,
    output logic [5:0] last_fail,
    output logic       pass
);
    state_t     state_q;
    logic [5:0] idx_q;
    logic [6:0] err_q;
    logic [5:0] fail_q;
    logic       busy_q;
    logic       done_q;

    logic       tick;
    logic       start_ok;
    logic       advance;
    logic       mismatch;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    // Mode is consulted every APPLY cycle, so a mid-sweep switch applies immediately.
    assign advance  = mode ? step : tick;
    assign mismatch = alu_result != alu_golden(idx_q[3:2], idx_q[1:0], idx_q[5:4]);

    alu_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_ok || (state_q == CHECK)),
        .en_i  ((state_q == APPLY) && !mode),
        .tick_o(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= APPLY;
                        idx_q   <= '0;
                        err_q   <= '0;
                        fail_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (advance) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_q  <= err_q + 7'd1;
                        fail_q <= idx_q;
                    end
                    if (idx_q == 6'd63) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 6'd1;
                        state_q <= APPLY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_op    = idx_q[5:4];
    assign alu_a     = idx_q[3:2];
    assign alu_b     = idx_q[1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign last_fail = fail_q;
    assign pass      = done_q && (err_q == 7'd0);

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench: three sweep drivers (TICK_DIV 1, 3 with a faulty ADD, and 2)
// each attached to its own bench-side ALU.
module tb_alu_sweep_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [3];
    logic       start [3];
    logic       mode  [3];
    logic       step  [3];
    logic [1:0] a     [3];
    logic [1:0] b     [3];
    logic [1:0] op    [3];
    logic [1:0] res   [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [6:0] err   [3];
    logic [5:0] lf    [3];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [1:0] bench_alu(input logic [1:0] o, input logic [1:0] x,
                                             input logic [1:0] y, input bit fault);
        logic [1:0] r;
        case (o)
            2'd0:    r = x & y;
            2'd1:    r = x | y;
            2'd2:    r = x + y;
            default: r = x - y;
        endcase
        if (fault && o == 2'd2) r[0] = 1'b0;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TD = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        assign res[g] = bench_alu(op[g], a[g], b[g], g == 1);
        alu_sweep_driver #(.TICK_DIV(TD)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .start     (start[g]),
            .mode      (mode[g]),
            .step      (step[g]),
            .alu_a     (a[g]),
            .alu_b     (b[g]),
            .alu_op    (op[g]),
            .alu_result(res[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .err_count (err[g]),
            .last_fail (lf[g]),
            .pass      (pass[g])
        );
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int idx_of(input int i);
        return int'({op[i], a[i], b[i]});
    endfunction

    task automatic chk_status(input int i, input string tag, input int e_idx, input int e_busy,
                              input int e_done, input int e_err, input int e_lf, input int e_pass);
        chk({tag, ".idx"},  idx_of(i),   e_idx);
        chk({tag, ".busy"}, int'(busy[i]), e_busy);
        chk({tag, ".done"}, int'(done[i]), e_done);
        chk({tag, ".err"},  int'(err[i]),  e_err);
        chk({tag, ".lf"},   int'(lf[i]),   e_lf);
        chk({tag, ".pass"}, int'(pass[i]), e_pass);
    endtask

    // Pulses start, then counts cycles until done rises (limit on timeout).
    task automatic run_to_done(input int i, input int limit, output int lat);
        start[i] = 1'b1;
        cyc(1);
        start[i] = 1'b0;
        lat = limit;
        for (int c = 1; c <= limit; c++) begin
            cyc(1);
            if (done[i]) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; mode[i] = 1'b0; step[i] = 1'b0;
        end
        cyc(3);
        for (int i = 0; i < 3; i++) chk_status(i, "reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        cyc(1);

        // step with no start does nothing
        mode[0] = 1'b1; step[0] = 1'b1;
        cyc(1);
        step[0] = 1'b0;
        cyc(2);
        chk_status(0, "step_idle", 0, 0, 0, 0, 0, 0);
        mode[0] = 1'b0;

        // TICK_DIV=1 full sweep, index order, with an ignored start mid-sweep
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        lat = 300;
        for (int c = 1; c <= 300; c++) begin
            if (c == 20) start[0] = 1'b1;
            if (c == 21) start[0] = 1'b0;
            cyc(1);
            if (done[0]) begin
                lat = c;
                break;
            end
            chk("auto1.idx", idx_of(0), c / 2);
            if (c == 64) chk("auto1.busy", int'(busy[0]), 1);
        end
        chk("auto1.done_lat", lat, 128);
        chk_status(0, "auto1.end", 63, 0, 1, 0, 0, 1);

        // TICK_DIV=3 with ADD bit 0 stuck low: 8 failures, last is 6'b101110
        start[1] = 1'b1;
        cyc(1);
        start[1] = 1'b0;
        lat = 400;
        for (int c = 1; c <= 400; c++) begin
            cyc(1);
            if (c == 135) chk("fault.err_pre", int'(err[1]), 0);
            if (c == 136) begin
                chk("fault.err_first", int'(err[1]), 1);
                chk("fault.lf_first", int'(lf[1]), 33);
            end
            if (done[1]) begin
                lat = c;
                break;
            end
        end
        chk("fault.done_lat", lat, 256);
        chk_status(1, "fault.end", 63, 0, 1, 8, 46, 0);
        start[1] = 1'b1;
        cyc(1);
        start[1] = 1'b0;
        chk_status(1, "fault.restart", 0, 1, 0, 0, 0, 0);
        rst_n[1] = 1'b0;

        // Step mode from DONE: three steps spaced 5 cycles apart
        mode[0] = 1'b1; start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        chk_status(0, "step.start", 0, 1, 0, 0, 0, 0);
        cyc(4);
        chk("step.hold", idx_of(0), 0);
        for (int k = 1; k <= 3; k++) begin
            step[0] = 1'b1;
            cyc(1);
            step[0] = 1'b0;
            chk("step.check_idx", idx_of(0), k - 1);
            cyc(1);
            chk("step.next_idx", idx_of(0), k);
            cyc(3);
        end
        chk_status(0, "step.end", 3, 1, 0, 0, 0, 0);
        mode[0] = 1'b0;
        cyc(2);
        chk("step2auto.idx", idx_of(0), 4);
        rst_n[0] = 1'b0;

        // start and step together in IDLE: start wins, step dropped
        mode[2] = 1'b1; start[2] = 1'b1; step[2] = 1'b1;
        cyc(1);
        start[2] = 1'b0; step[2] = 1'b0;
        cyc(3);
        chk_status(2, "start_step", 0, 1, 0, 0, 0, 0);
        rst_n[2] = 1'b0;
        cyc(1);
        rst_n[2] = 1'b1;
        mode[2] = 1'b0;
        chk_status(2, "rst_step", 0, 0, 0, 0, 0, 0);

        // TICK_DIV=2: reset mid-sweep, then a full sweep with step held high
        start[2] = 1'b1;
        cyc(1);
        start[2] = 1'b0;
        cyc(49);
        chk("midrst.idx_pre", idx_of(2), 16);
        rst_n[2] = 1'b0;
        cyc(1);
        rst_n[2] = 1'b1;
        chk_status(2, "midrst", 0, 0, 0, 0, 0, 0);
        step[2] = 1'b1;
        run_to_done(2, 400, lat);
        step[2] = 1'b0;
        chk("auto2.done_lat", lat, 192);
        chk_status(2, "auto2.end", 63, 0, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
